regfile_writeback: RTL and testbench
====================================

// Module: regfile_writeback
// PURPOSE
//  Write-side front end of the register file. It arbitrates result streams from the
//  execution units (ALU, load, mul/div) onto the single register-file write port (we/A3/wd).
//  It also keeps a busy scoreboard of destination registers so that issue logic can stall on RAW hazards.
//  Sits between the execution units and register_file in the rv32ima core.
// PARAMETERS
//  NUM_SRC         3   number of result sources (valid/ready streams)
//  REGISTER_WIDTH  32  data width of results and wd
//  REGISTER_DEPTH  32  number of architectural registers; address width is fixed at 5
// PORTS
//  clk           in   1                  core clock, all state on rising edge
//  resetn        in   1                  asynchronous, active-low reset
//  issue_valid   in   1                  issue stage reserves a destination
//  issue_rd      in   5                  destination register being reserved
//  issue_ready   out  1                  reservation accepted this cycle
//  src_valid     in   NUM_SRC            per-source result valid
//  src_ready     out  NUM_SRC            per-source grant (one-hot or zero)
//  src_rd        in   NUM_SRC*5          per-source destination, source i at [5i+:5]
//  src_data      in   NUM_SRC*REG_W      per-source result, source i at [W*i+:W]
//  we            out  1                  register-file write enable
//  A3            out  5                  register-file write address
//  wd            out  REG_W              register-file write data
//  chk_rs1       in   5                  issue-stage source 1 lookup
//  chk_rs2       in   5                  issue-stage source 2 lookup
//  rs1_busy      out  1                  chk_rs1 has an outstanding producer
//  rs2_busy      out  1                  chk_rs2 has an outstanding producer
//  fwd1_hit      out  1                  wd may be used for rs1 this cycle (bypass only)
//  fwd2_hit      out  1                  wd may be used for rs2 this cycle (bypass only)
// BEHAVIOUR
//  Reset (async, resetn=0): we=0, A3=0, wd=0, busy[*]=0, rr_ptr=0, src_ready=0, issue_ready=0.
//   In-flight results are discarded. Outputs stay at these values until the first rising edge after release.
//  Issue: issue_ready = resetn & (issue_rd==0 | ~busy[issue_rd]).
//   On issue_valid & issue_ready with rd!=0, busy[rd] is set at the next edge. rd==0 is accepted and ignored.
//  Arbitration: round-robin, combinational. src_ready[i]=1 for the first valid source at or after rr_ptr.
//   src_ready may depend combinationally on src_valid. At most one grant per cycle.
//   After a grant to source g, rr_ptr <= (g+1) mod NUM_SRC. rr_ptr holds when there is no grant.
//  Output stage: registered and never stalls; throughput is 1 write/cycle.
//   A handshake in cycle N gives we=1, A3=src_rd[g], wd=src_data[g] in cycle N+1.
//   With no handshake in cycle N, we=0 in N+1 and A3/wd hold their previous values.
//   A granted result with rd==0 is consumed but gives we=0.
//  Scoreboard clear: busy[A3] clears at the edge that ends a we=1 cycle, the same edge where register_file captures wd.
//  Simultaneous set and clear on the same rd at one edge: set wins and busy stays 1.
//   This can only occur as a new issue in the writeback cycle.
//  A result whose rd is not busy is still written; the scoreboard is unchanged.
//  rsX_busy = (chk_rsX!=0) & busy[chk_rsX], combinational.
// CONFIGURATION
//  `WB_BYPASS_EN defined: in a cycle with we=1 and chk_rsX==A3!=0:
//   fwdX_hit=1 and rsX_busy=0, so the consumer reads wd directly, one cycle earlier.
//   This applies only when the same cycle has no set of busy[A3].
//  `WB_BYPASS_EN undefined: fwd1_hit=fwd2_hit=0 constant. rsX_busy follows busy[] only.
//   The consumer waits until the cycle after we.
// STRUCTURE
//  Package wb_pkg: localparam REG_ADDR_W=5, REG_ZERO=5'd0, and a function for the NUM_SRC index width ($clog2 guard for 1).
//  Sub-module wb_rr_arbiter: NUM_SRC-wide round-robin, with request vector in and one-hot grant plus index out.
//   It holds rr_ptr internally and takes the same clk/resetn.
//  Top module: issue/scoreboard logic, data mux, output register and bypass compare.
// TESTING
//  Reset: resetn=0 mid-stream with src_valid=3'b111 -> we=0, src_ready=0 and busy all clear immediately.
//   The first write after release comes from source 0.
//  Single path: issue rd=5; src1 returns 32'hDEADBEEF rd=5 in cycle 10 -> we=1, A3=5, wd=DEADBEEF in cycle 11.
//   rs1_busy(chk=5) is 1 through cycle 11 (no bypass) and 0 from cycle 12.
//  Fairness: all three sources valid continuously -> grants 0,1,2,0,1,2. No source waits more than 2 cycles.
//  x0: issue rd=0 -> issue_ready=1 and busy unchanged. Result with rd=0 -> src_ready=1, we=0.
//  Hazard: issue rd=7 twice back-to-back -> second issue_ready=0.
//   Writeback of rd 7 plus issue rd 7 at the same edge -> busy[7] stays 1.
//  `WB_BYPASS_EN: in the we cycle with A3=9 and chk_rs2=9 -> fwd2_hit=1, rs2_busy=0.
//   Without the macro -> fwd2_hit=0, rs2_busy=1.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared constants and helpers for the register-file writeback front end.
// Optional forwarding build: define WB_BYPASS_EN (see regfile_writeback.sv).
package wb_pkg;

   localparam int         REG_ADDR_W = 5;
   localparam logic [4:0] REG_ZERO   = 5'd0;

   // Index width for an n-entry selector; a single source still needs one bit.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/wb_rr_arbiter.sv
// Round-robin arbiter: one-hot grant plus encoded index, pointer advances past the winner.
module wb_rr_arbiter
   import wb_pkg::*;
#(
   parameter int NUM_SRC = 3,
   parameter int IDX_W   = idx_w(NUM_SRC)
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic [NUM_SRC-1:0] req,
   output logic [NUM_SRC-1:0] gnt,
   output logic [IDX_W-1:0]   gnt_idx,
   output logic               gnt_vld
);

   logic [IDX_W-1:0] rr_ptr;

   // Scan from rr_ptr, wrapping, and take the first requester.
   always_comb begin
      int p;
      gnt     = '0;
      gnt_idx = '0;
      gnt_vld = 1'b0;
      p       = 0;
      for (int k = 0; k < NUM_SRC; k++) begin
         p = int'(rr_ptr) + k;
         if (p >= NUM_SRC) p = p - NUM_SRC;
         if (!gnt_vld && req[p]) begin
            gnt[p]  = 1'b1;
            gnt_idx = IDX_W'(p);
            gnt_vld = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rr_ptr <= '0;
      end else if (gnt_vld) begin
         rr_ptr <= (int'(gnt_idx) == NUM_SRC - 1) ? '0 : gnt_idx + 1'b1;
      end
   end

endmodule

// File: rtl/regfile_writeback.sv
// Arbitrates execution-unit results onto the register-file write port and tracks busy destinations.
// Define WB_BYPASS_EN to let issue consume wd in the write cycle instead of waiting one cycle.
module regfile_writeback
   import wb_pkg::*;
#(
   parameter int NUM_SRC        = 3,
   parameter int REGISTER_WIDTH = 32,
   parameter int REGISTER_DEPTH = 32
) (
   input  logic                              clk,
   input  logic                              resetn,
   input  logic                              issue_valid,
   input  logic [REG_ADDR_W-1:0]             issue_rd,
   output logic                              issue_ready,
   input  logic [NUM_SRC-1:0]                src_valid,
   output logic [NUM_SRC-1:0]                src_ready,
   input  logic [NUM_SRC*REG_ADDR_W-1:0]     src_rd,
   input  logic [NUM_SRC*REGISTER_WIDTH-1:0] src_data,
   output logic                              we,
   output logic [REG_ADDR_W-1:0]             A3,
   output logic [REGISTER_WIDTH-1:0]         wd,
   input  logic [REG_ADDR_W-1:0]             chk_rs1,
   input  logic [REG_ADDR_W-1:0]             chk_rs2,
   output logic                              rs1_busy,
   output logic                              rs2_busy,
   output logic                              fwd1_hit,
   output logic                              fwd2_hit
);

   localparam int IDX_W = idx_w(NUM_SRC);

   logic [REGISTER_DEPTH-1:0] busy;
   logic [REGISTER_DEPTH-1:0] busy_nxt;
   logic [NUM_SRC-1:0]        gnt_p0;
   logic [IDX_W-1:0]          gnt_idx_p0;
   logic                      vld_p0;
   logic [REG_ADDR_W-1:0]     sel_rd_p0;
   logic [REGISTER_WIDTH-1:0] sel_data_p0;
   logic                      issue_fire;
   logic                      set_on_a3;

   // ---- stage p0: reservation, arbitration and result select ----
   assign issue_ready = resetn & ((issue_rd == REG_ZERO) | ~busy[issue_rd]);
   assign issue_fire  = issue_valid & issue_ready & (issue_rd != REG_ZERO);

   wb_rr_arbiter #(
      .NUM_SRC (NUM_SRC),
      .IDX_W   (IDX_W)
   ) u_arb (
      .clk     (clk),
      .resetn  (resetn),
      .req     (src_valid & {NUM_SRC{resetn}}),
      .gnt     (gnt_p0),
      .gnt_idx (gnt_idx_p0),
      .gnt_vld (vld_p0)
   );

   assign src_ready   = gnt_p0;
   assign sel_rd_p0   = src_rd[int'(gnt_idx_p0)*REG_ADDR_W +: REG_ADDR_W];
   assign sel_data_p0 = src_data[int'(gnt_idx_p0)*REGISTER_WIDTH +: REGISTER_WIDTH];

   // ---- stage p1: write port register (never stalls) ----
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         we <= 1'b0;
         A3 <= '0;
         wd <= '0;
      end else begin
         we <= vld_p0 & (sel_rd_p0 != REG_ZERO);
         if (vld_p0 && sel_rd_p0 != REG_ZERO) begin
            A3 <= sel_rd_p0;
            wd <= sel_data_p0;
         end
      end
   end

   // Clear for the retiring write first, so a same-edge reservation of that rd wins.
   always_comb begin
      busy_nxt = busy;
      if (we) busy_nxt[A3] = 1'b0;
      if (issue_fire) busy_nxt[issue_rd] = 1'b1;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) busy <= '0;
      else         busy <= busy_nxt;
   end

   assign set_on_a3 = issue_fire & (issue_rd == A3);

`ifdef WB_BYPASS_EN
   assign fwd1_hit = we & (A3 != REG_ZERO) & (chk_rs1 == A3) & ~set_on_a3;
   assign fwd2_hit = we & (A3 != REG_ZERO) & (chk_rs2 == A3) & ~set_on_a3;
`else
   assign fwd1_hit = 1'b0;
   assign fwd2_hit = 1'b0;
`endif

   assign rs1_busy = (chk_rs1 != REG_ZERO) & busy[chk_rs1] & ~fwd1_hit;
   assign rs2_busy = (chk_rs2 != REG_ZERO) & busy[chk_rs2] & ~fwd2_hit;

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed bench for regfile_writeback: reset, arbitration, scoreboard and bypass behaviour.
module tb_regfile_writeback;

   logic        clk = 1'b0;
   logic        resetn;
   logic        issue_valid;
   logic [4:0]  issue_rd;
   logic        issue_ready;
   logic [2:0]  src_valid;
   logic [2:0]  src_ready;
   logic [14:0] src_rd;
   logic [95:0] src_data;
   logic        we;
   logic [4:0]  A3;
   logic [31:0] wd;
   logic [4:0]  chk_rs1;
   logic [4:0]  chk_rs2;
   logic        rs1_busy;
   logic        rs2_busy;
   logic        fwd1_hit;
   logic        fwd2_hit;

   int checks = 0;
   int errors = 0;

`ifdef WB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   regfile_writeback dut (
      .clk         (clk),
      .resetn      (resetn),
      .issue_valid (issue_valid),
      .issue_rd    (issue_rd),
      .issue_ready (issue_ready),
      .src_valid   (src_valid),
      .src_ready   (src_ready),
      .src_rd      (src_rd),
      .src_data    (src_data),
      .we          (we),
      .A3          (A3),
      .wd          (wd),
      .chk_rs1     (chk_rs1),
      .chk_rs2     (chk_rs2),
      .rs1_busy    (rs1_busy),
      .rs2_busy    (rs2_busy),
      .fwd1_hit    (fwd1_hit),
      .fwd2_hit    (fwd2_hit)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_src(input int i, input logic [4:0] rd, input logic [31:0] d);
      src_rd[i*5 +: 5]    = rd;
      src_data[i*32 +: 32] = d;
   endtask

   task automatic test_reset();
      resetn = 1'b0; issue_valid = 1'b0; issue_rd = '0; src_valid = '0;
      src_rd = '0; src_data = '0; chk_rs1 = '0; chk_rs2 = '0;
      tick(); tick();
      checks++; if (we !== 1'b0 || A3 !== 5'd0 || wd !== 32'd0) begin
         errors++; $display("FAIL reset_outputs: we=%b A3=%0d wd=%h, need 0/0/0", we, A3, wd); end
      checks++; if (src_ready !== 3'b000 || issue_ready !== 1'b0) begin
         errors++; $display("FAIL reset_ready: src_ready=%b issue_ready=%b, need 000/0", src_ready, issue_ready); end
      resetn = 1'b1;
      issue_valid = 1'b1; issue_rd = 5'd3; #1;
      checks++; if (issue_ready !== 1'b1) begin
         errors++; $display("FAIL issue_after_reset: issue_ready=%b, need 1", issue_ready); end
      tick();
      issue_valid = 1'b0; chk_rs1 = 5'd3;
      set_src(0, 5'd1, 32'h1111_0000); set_src(1, 5'd2, 32'h2222_0000); set_src(2, 5'd4, 32'h4444_0000);
      src_valid = 3'b111; #1;
      checks++; if (rs1_busy !== 1'b1) begin
         errors++; $display("FAIL busy_set_rd3: rs1_busy=%b, need 1", rs1_busy); end
      tick();
      // Reset mid-stream: everything must drop without waiting for a clock.
      resetn = 1'b0; #1;
      checks++; if (we !== 1'b0 || src_ready !== 3'b000 || rs1_busy !== 1'b0) begin
         errors++; $display("FAIL async_reset: we=%b src_ready=%b rs1_busy=%b, need 0/000/0", we, src_ready, rs1_busy); end
      tick();
      resetn = 1'b1; #1;
      checks++; if (src_ready !== 3'b001) begin
         errors++; $display("FAIL first_grant: src_ready=%b, need 001", src_ready); end
      tick();
      checks++; if (we !== 1'b1 || A3 !== 5'd1 || wd !== 32'h1111_0000) begin
         errors++; $display("FAIL first_write: we=%b A3=%0d wd=%h, need 1/1/11110000", we, A3, wd); end
   endtask

   // Pointer is 1 on entry (source 0 just won), so the rotation continues 1,2,0,1,2,0.
   task automatic test_fairness();
      logic [4:0] rds [3];
      rds[0] = 5'd1; rds[1] = 5'd2; rds[2] = 5'd4;
      for (int k = 0; k < 6; k++) begin
         int g;
         g = (1 + k) % 3;
         checks++; if (src_ready !== (3'b001 << g)) begin
            errors++; $display("FAIL rr_grant_%0d: src_ready=%b, need %b", k, src_ready, 3'b001 << g); end
         tick();
         checks++; if (we !== 1'b1 || A3 !== rds[g]) begin
            errors++; $display("FAIL rr_write_%0d: we=%b A3=%0d, need 1/%0d", k, we, A3, rds[g]); end
      end
      src_valid = 3'b000;
   endtask

   task automatic test_single_path();
      issue_valid = 1'b1; issue_rd = 5'd5;
      tick();
      issue_valid = 1'b0; chk_rs1 = 5'd5;
      set_src(1, 5'd5, 32'hDEAD_BEEF); src_valid = 3'b010; #1;
      checks++; if (src_ready !== 3'b010 || rs1_busy !== 1'b1) begin
         errors++; $display("FAIL single_grant: src_ready=%b rs1_busy=%b, need 010/1", src_ready, rs1_busy); end
      tick();
      src_valid = 3'b000; #1;
      checks++; if (we !== 1'b1 || A3 !== 5'd5 || wd !== 32'hDEAD_BEEF) begin
         errors++; $display("FAIL single_write: we=%b A3=%0d wd=%h, need 1/5/deadbeef", we, A3, wd); end
      checks++; if (rs1_busy !== !BYP || fwd1_hit !== BYP) begin
         errors++; $display("FAIL single_wb_cycle: rs1_busy=%b fwd1_hit=%b, need %b/%b", rs1_busy, fwd1_hit, !BYP, BYP); end
      tick();
      checks++; if (we !== 1'b0 || A3 !== 5'd5 || wd !== 32'hDEAD_BEEF || rs1_busy !== 1'b0) begin
         errors++; $display("FAIL single_after: we=%b A3=%0d wd=%h rs1_busy=%b, need 0/5/deadbeef/0", we, A3, wd, rs1_busy); end
   endtask

   task automatic test_x0();
      chk_rs1 = 5'd0; issue_valid = 1'b1; issue_rd = 5'd0; #1;
      checks++; if (issue_ready !== 1'b1) begin
         errors++; $display("FAIL x0_issue: issue_ready=%b, need 1", issue_ready); end
      tick();
      issue_valid = 1'b0;
      set_src(0, 5'd0, 32'hCAFE_F00D); src_valid = 3'b001; #1;
      checks++; if (src_ready !== 3'b001 || rs1_busy !== 1'b0) begin
         errors++; $display("FAIL x0_grant: src_ready=%b rs1_busy=%b, need 001/0", src_ready, rs1_busy); end
      tick();
      src_valid = 3'b000; #1;
      checks++; if (we !== 1'b0) begin
         errors++; $display("FAIL x0_write: we=%b, need 0", we); end
   endtask

   task automatic test_hazard();
      chk_rs2 = 5'd7; issue_valid = 1'b1; issue_rd = 5'd7; #1;
      checks++; if (issue_ready !== 1'b1) begin
         errors++; $display("FAIL hazard_first: issue_ready=%b, need 1", issue_ready); end
      tick();
      checks++; if (issue_ready !== 1'b0 || rs2_busy !== 1'b1) begin
         errors++; $display("FAIL hazard_second: issue_ready=%b rs2_busy=%b, need 0/1", issue_ready, rs2_busy); end
      tick();
      issue_valid = 1'b0;
      set_src(2, 5'd7, 32'h0000_0077); src_valid = 3'b100;
      tick();
      src_valid = 3'b000; #1;
      checks++; if (we !== 1'b1 || A3 !== 5'd7 || rs2_busy !== !BYP) begin
         errors++; $display("FAIL hazard_wb: we=%b A3=%0d rs2_busy=%b, need 1/7/%b", we, A3, rs2_busy, !BYP); end
      tick();
      checks++; if (rs2_busy !== 1'b0) begin
         errors++; $display("FAIL hazard_clear: rs2_busy=%b, need 0", rs2_busy); end
      // Unreserved rd 7 is still written; re-reserving it in that write cycle must stick.
      set_src(0, 5'd7, 32'h0000_1234); src_valid = 3'b001;
      tick();
      src_valid = 3'b000; issue_valid = 1'b1; issue_rd = 5'd7; #1;
      checks++; if (we !== 1'b1 || wd !== 32'h0000_1234 || issue_ready !== 1'b1 || fwd2_hit !== 1'b0) begin
         errors++; $display("FAIL collide_cycle: we=%b wd=%h issue_ready=%b fwd2_hit=%b, need 1/1234/1/0", we, wd, issue_ready, fwd2_hit); end
      tick();
      issue_valid = 1'b0; #1;
      checks++; if (rs2_busy !== 1'b1) begin
         errors++; $display("FAIL collide_set_wins: rs2_busy=%b, need 1", rs2_busy); end
   endtask

   task automatic test_bypass();
      issue_valid = 1'b1; issue_rd = 5'd9;
      tick();
      issue_valid = 1'b0; chk_rs2 = 5'd9; chk_rs1 = 5'd8;
      set_src(1, 5'd9, 32'h9999_9999); src_valid = 3'b010;
      tick();
      src_valid = 3'b000; #1;
      checks++; if (we !== 1'b1 || A3 !== 5'd9 || fwd2_hit !== BYP || rs2_busy !== !BYP) begin
         errors++; $display("FAIL bypass_wb: we=%b A3=%0d fwd2_hit=%b rs2_busy=%b, need 1/9/%b/%b", we, A3, fwd2_hit, rs2_busy, BYP, !BYP); end
      checks++; if (fwd1_hit !== 1'b0 || rs1_busy !== 1'b0) begin
         errors++; $display("FAIL bypass_other_reg: fwd1_hit=%b rs1_busy=%b, need 0/0", fwd1_hit, rs1_busy); end
      tick();
      checks++; if (fwd2_hit !== 1'b0 || rs2_busy !== 1'b0 || we !== 1'b0) begin
         errors++; $display("FAIL bypass_after: fwd2_hit=%b rs2_busy=%b we=%b, need 0/0/0", fwd2_hit, rs2_busy, we); end
   endtask

   initial begin
      test_reset();
      test_fairness();
      test_single_path();
      test_x0();
      test_hazard();
      test_bypass();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
